crc32_byte: RTL and testbench
=============================

CRC32_BYTE -- requirements
Module: crc32_byte

Interface
REQ-001 SHALL have no parameters; polynomial 0x04C11DB7, init value 0xFFFFFFFF and output complement are fixed.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset; the team's active-low reset naming.
REQ-005 init  input  1  synchronous restart of the CRC for a new frame, active high.
REQ-006 data_in  input  8  data byte; bit 0 is the first bit on the wire.
REQ-007 data_valid  input  1  absorb data_in into the CRC on this edge.
REQ-008 crc_out  output  32  complement of the CRC register; bit 31 is the first FCS bit transmitted.
REQ-009 crc_ok  output  1  high when the CRC register equals the Ethernet residue 0xC704DD7B.

Function
REQ-010 SHALL hold a 32-bit CRC register C, MSB-first (C[31] = x^31 coefficient).
REQ-011 When data_valid=1 and init=0 on a rising edge, C SHALL be updated once for a whole byte:
- process data_in[0] first, then data_in[1] .. data_in[7];
- per bit: fb = C[31] XOR d; C = (C << 1) XOR (fb ? 0x04C11DB7 : 0);
- all 8 steps complete within one clock.
REQ-012 When data_valid=0 and init=0, C SHALL hold its value.
REQ-013 init=1 SHALL load C=0xFFFFFFFF on that edge, with priority over data_valid; the byte presented that cycle is discarded.
REQ-014 crc_out SHALL be the combinational bitwise NOT of C: no extra register, no bit reversal.
- Latency: crc_out reflects a byte on the first edge after data_valid sampled it.
REQ-015 crc_ok SHALL be combinational: (C == 0xC704DD7B).
REQ-016 A frame SHALL be usable directly by an Ethernet MII transmitter:
- the MAC sends nibble k (k=0..7) as txd = {crc_out[28-4k], crc_out[29-4k], crc_out[30-4k], crc_out[31-4k]};
- this yields the IEEE 802.3 FCS.
REQ-017 Back-to-back data_valid SHALL be supported every cycle with no gaps; there is no ready/backpressure signal.
REQ-018 data_valid asserted sparsely (e.g. every other cycle) SHALL give the same result as a contiguous stream of the same bytes.
REQ-019 X on data_in while data_valid=0 SHALL NOT affect C.

Reset
REQ-020 rstn=0 SHALL immediately, asynchronously, set C=0xFFFFFFFF, independent of clk. Resulting outputs: crc_out=0x00000000, crc_ok=0.
REQ-021 Release of rstn SHALL be treated as synchronized externally.
REQ-022 The first edge after release SHALL process inputs normally.
REQ-023 Reset asserted mid-frame SHALL abandon the partial CRC with no residual state.

Verification
REQ-024 After reset, no valid bytes -> crc_out=0x00000000, crc_ok=0.
REQ-025 init, then bytes "123456789" (0x31..0x39) on consecutive cycles -> crc_out=0x649C2FD3.
- This is the bit-reverse of the standard CRC-32 check value 0xCBF43926.
REQ-026 Continue the REQ-025 frame with FCS bytes 0x26, 0x39, 0xF4, 0xCB -> crc_ok=1, crc_out=0x38FB2284.
REQ-027 Same 9 bytes with data_valid toggling 1/0 every cycle and random data_in on idle cycles -> crc_out=0x649C2FD3.
REQ-028 Mid-frame, assert init together with data_valid, then send "123456789" -> crc_out=0x649C2FD3; the byte presented with init is ignored.
REQ-029 Mid-frame, assert rstn=0 between clock edges -> crc_out=0x00000000 immediately; a subsequent "123456789" gives 0x649C2FD3.

Source files
------------

// File: rtl/crc32_byte_if.sv
// Byte-stream bus of the CRC-32 engine: data in, running FCS and residue flag out.
interface crc32_byte_if;
  logic        init;
  logic [7:0]  data_in;
  logic        data_valid;
  logic [31:0] crc_out;
  logic        crc_ok;

  // Byte source / FCS consumer side
  modport master (
    output init,
    output data_in,
    output data_valid,
    input  crc_out,
    input  crc_ok
  );

  // CRC engine side
  modport slave (
    input  init,
    input  data_in,
    input  data_valid,
    output crc_out,
    output crc_ok
  );
endinterface

// File: rtl/crc32_byte.sv
// Ethernet CRC-32, one byte per clock. The register is kept MSB-first while data
// bits enter LSB-first, so ~crc_q is the FCS in the transmit order of an MII MAC.
module crc32_byte (
  input logic         clk,
  input logic         rstn,
  crc32_byte_if.slave bus
);

  localparam logic [31:0] Poly    = 32'h04C1_1DB7;
  localparam logic [31:0] Seed    = 32'hFFFF_FFFF;
  localparam logic [31:0] Residue = 32'hC704_DD7B;

  logic [31:0] crc_q, crc_d;

  // Eight serial LFSR steps unrolled; data_in[0] is the first bit on the wire
  function automatic logic [31:0] step_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0} ^ (fb ? Poly : 32'h0);
    end
    return r;
  endfunction

  // Next state: init restarts the frame and wins over a byte presented the same cycle
  always_comb begin
    crc_d = crc_q;
    if (bus.init) begin
      crc_d = Seed;
    end else if (bus.data_valid) begin
      crc_d = step_byte(crc_q, bus.data_in);
    end
  end

  // CRC register; reset abandons any partial frame
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc_q <= Seed;
    end else begin
      crc_q <= crc_d;
    end
  end

  // Outputs are purely combinational views of the register
  always_comb begin
    bus.crc_out = ~crc_q;
    bus.crc_ok  = (crc_q == Residue);
  end

endmodule

// File: tb/tb_crc32_byte.sv
// Directed bench for crc32_byte: stimulus queues expected results, a negedge monitor checks them.
module tb_crc32_byte;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  crc32_byte_if bus ();

  crc32_byte dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] crc;
    logic        ok;
  } exp_t;

  exp_t        sb[$];
  logic        sample = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  logic [7:0]  fcs [4] = '{8'h26, 8'h39, 8'hF4, 8'hCB};

  // Monitor: pops one expectation per requested sample and compares both outputs
  always @(negedge clk) begin
    if (sample) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: sample requested with no expectation queued");
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (bus.crc_out !== e.crc) begin
          errors++;
          $display("FAIL %s crc_out: got %08h expected %08h", e.name, bus.crc_out, e.crc);
        end
        checks++;
        if (bus.crc_ok !== e.ok) begin
          errors++;
          $display("FAIL %s crc_ok: got %0b expected %0b", e.name, bus.crc_ok, e.ok);
        end
      end
    end
  end

  // Present inputs, then let one rising edge pass
  task automatic drive(input logic i, input logic v, input logic [7:0] d);
    bus.init       = i;
    bus.data_valid = v;
    bus.data_in    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_msg(input bit sparse);
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, 1'b1, msg[k]);
      if (sparse) drive(1'b0, 1'b0, 8'($urandom));
    end
  endtask

  // Queue an expectation and have the monitor sample at the next falling edge
  task automatic expect_out(input string n, input logic [31:0] c, input logic o);
    exp_t e;
    bus.data_valid = 1'b0;
    bus.init       = 1'b0;
    e.name = n;
    e.crc  = c;
    e.ok   = o;
    sb.push_back(e);
    sample = 1'b1;
    @(negedge clk);
    #1;
    sample = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.init       = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_in    = 8'h00;
    #12;
    expect_out("reset_asserted", 32'h0000_0000, 1'b0);
    rstn = 1'b1;

    // Idle cycles with random data must not disturb the register
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 8'($urandom));
    expect_out("idle_after_reset", 32'h0000_0000, 1'b0);

    // Standard check string
    drive(1'b1, 1'b0, 8'h00);
    send_msg(1'b0);
    expect_out("check_123456789", 32'h649C_2FD3, 1'b0);

    // Hold with undefined data while not valid
    drive(1'b0, 1'b0, 8'hxx);
    drive(1'b0, 1'b0, 8'hxx);
    expect_out("hold_idle_x", 32'h649C_2FD3, 1'b0);

    // Append FCS: register lands on the Ethernet residue
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, fcs[k]);
    expect_out("residue", 32'h38FB_2284, 1'b1);

    // init alone reloads the seed
    drive(1'b1, 1'b0, 8'h55);
    expect_out("init_only", 32'h0000_0000, 1'b0);

    // Sparse valid with random idle data
    send_msg(1'b1);
    expect_out("sparse_stream", 32'h649C_2FD3, 1'b0);

    // init together with data_valid mid-frame: the byte is discarded
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h12);
    drive(1'b0, 1'b1, 8'h34);
    drive(1'b1, 1'b1, 8'hAA);
    expect_out("init_priority", 32'h0000_0000, 1'b0);
    send_msg(1'b0);
    expect_out("after_init_mid_frame", 32'h649C_2FD3, 1'b0);

    // Asynchronous reset between edges mid-frame
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h31);
    drive(1'b0, 1'b1, 8'h32);
    rstn = 1'b0;
    expect_out("async_reset_mid_frame", 32'h0000_0000, 1'b0);
    rstn = 1'b1;
    send_msg(1'b0);
    expect_out("after_reset_frame", 32'h649C_2FD3, 1'b0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
